// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Brief    : Framed byte-stream boot loader feeding the instruction ROM write
//            port; releases the CPU once a checksum-verified image is loaded.
// Revision : 1.0
// ============================================================================
module rom_loader #(
    parameter int          ADDR_W    = 15,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [15:0] MAGIC     = 16'h484B,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [3:0] {
        S_SYNC0   = 4'd0,
        S_SYNC1   = 4'd1,
        S_LEN_HI  = 4'd2,
        S_LEN_LO  = 4'd3,
        S_DATA_HI = 4'd4,
        S_DATA_LO = 4'd5,
        S_CHECK   = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    localparam logic [32:0] c_max_len  = 33'((33'd1 << ADDR_W) - 33'(BASE_ADDR));
    localparam logic [31:0] c_tmo_last = 32'(TIMEOUT - 32'd1);

    state_t              r_state;
    logic [15:0]         r_length;
    logic [7:0]          r_hi;
    logic [7:0]          r_csum;
    logic [15:0]         r_index;
    logic [31:0]         r_timer;
    logic                r_byte_ready;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [15:0]         r_wr_data;
    logic                r_wr_en;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_error;
    logic [15:0]         r_words;

    logic                w_accept;
    logic                w_active;
    logic                w_in_frame;
    logic                w_timeout;
    logic [15:0]         w_len;
    logic [31:0]         w_addr_sum;

    assign w_accept   = byte_valid && r_byte_ready;
    assign w_active   = (r_state != S_DONE) && (r_state != S_ERROR);
    assign w_in_frame = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                        (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                        (r_state == S_CHECK);
    // Inter-byte watchdog: fires on the edge the idle count would reach TIMEOUT.
    assign w_timeout  = (TIMEOUT != 0) && w_in_frame && !w_accept &&
                        (r_timer == c_tmo_last);
    assign w_len      = {r_length[15:8], byte_in};
    assign w_addr_sum = BASE_ADDR + {16'd0, r_index};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SYNC0;
            r_length     <= 16'd0;
            r_hi         <= 8'd0;
            r_csum       <= 8'd0;
            r_index      <= 16'd0;
            r_timer      <= 32'd0;
            r_byte_ready <= 1'b0;
            r_wr_addr    <= ADDR_W'(BASE_ADDR);
            r_wr_data    <= 16'd0;
            r_wr_en      <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= 16'd0;
        end else begin
            r_wr_en      <= 1'b0;
            r_byte_ready <= w_active;
            if (w_in_frame && !w_accept) begin
                r_timer <= r_timer + 32'd1;
            end else begin
                r_timer <= 32'd0;
            end

            if (w_timeout) begin
                r_state      <= S_ERROR;
                r_error      <= 1'b1;
                r_byte_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_SYNC0: begin
                        if (w_accept && byte_in == MAGIC[15:8]) begin
                            r_state <= S_SYNC1;
                        end
                    end
                    S_SYNC1: begin
                        if (w_accept) begin
                            if (byte_in == MAGIC[7:0]) begin
                                r_state <= S_LEN_HI;
                            end else if (byte_in != MAGIC[15:8]) begin
                                r_state <= S_SYNC0;
                            end
                        end
                    end
                    S_LEN_HI: begin
                        if (w_accept) begin
                            r_length[15:8] <= byte_in;
                            r_state        <= S_LEN_LO;
                        end
                    end
                    S_LEN_LO: begin
                        if (w_accept) begin
                            r_length <= w_len;
                            r_csum   <= 8'd0;
                            r_index  <= 16'd0;
                            r_words  <= 16'd0;
                            if ({17'd0, w_len} > c_max_len) begin
                                r_state      <= S_ERROR;
                                r_error      <= 1'b1;
                                r_byte_ready <= 1'b0;
                            end else if (w_len == 16'd0) begin
                                r_state <= S_CHECK;
                            end else begin
                                r_state <= S_DATA_HI;
                            end
                        end
                    end
                    S_DATA_HI: begin
                        if (w_accept) begin
                            r_hi    <= byte_in;
                            r_csum  <= r_csum + byte_in;
                            r_state <= S_DATA_LO;
                        end
                    end
                    S_DATA_LO: begin
                        if (w_accept) begin
                            r_csum    <= r_csum + byte_in;
                            r_wr_en   <= 1'b1;
                            r_wr_data <= {r_hi, byte_in};
                            r_wr_addr <= w_addr_sum[ADDR_W-1:0];
                            r_index   <= r_index + 16'd1;
                            r_words   <= r_words + 16'd1;
                            if (r_index + 16'd1 == r_length) begin
                                r_state <= S_CHECK;
                            end else begin
                                r_state <= S_DATA_HI;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (w_accept) begin
                            r_byte_ready <= 1'b0;
                            if (byte_in == r_csum) begin
                                r_state     <= S_DONE;
                                r_done      <= 1'b1;
                                r_cpu_reset <= 1'b0;
                            end else begin
                                r_state <= S_ERROR;
                                r_error <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        if (start) begin
                            r_state      <= S_SYNC0;
                            r_done       <= 1'b0;
                            r_cpu_reset  <= 1'b1;
                            r_byte_ready <= 1'b1;
                        end
                    end
                    S_ERROR: begin
                        if (start) begin
                            r_state      <= S_SYNC0;
                            r_error      <= 1'b0;
                            r_byte_ready <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_SYNC0;
                    end
                endcase
            end
        end
    end

    assign byte_ready   = r_byte_ready;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign wr_en        = r_wr_en;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction ROM (32K x 16).
- Receives a framed byte stream over a valid/ready handshake from a UART or host bridge and assembles big-endian 16-bit words.
- Writes each word into the ROM write port at consecutive addresses.
- Holds the CPU in reset until a complete, checksum-verified image has been loaded.

Parameters:
ADDR_W, 15, width of ROM write address (32K words)
BASE_ADDR, 0, first ROM address written
MAGIC, 16'h484B, two-byte frame sync word ("HK"), high byte first
TIMEOUT, 1000000, max clk cycles between accepted bytes inside a frame; 0 disables timeout

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; re-arms loader from DONE or ERROR
byte_in  input  8  incoming stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader can accept a byte
wr_addr  output  ADDR_W  ROM write address
wr_data  output  16  ROM write data
wr_en  output  1  ROM write strobe, one cycle per word
cpu_reset  output  1  active-high hold for the CPU
done  output  1  image loaded and verified
error  output  1  frame rejected (checksum, length or timeout)
words_loaded  output  16  count of words written in the current frame

Behaviour:
- Reset (rst_n low, asynchronous): state SYNC0; byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_reset=1, done=0, error=0, words_loaded=0, checksum=0, timeout counter=0.
- byte_ready is registered. It is 1 from the first clk edge after reset release while in SYNC0..CHECK, and 0 in DONE/ERROR.
- A byte is accepted on a rising edge with byte_valid && byte_ready. No other edge consumes byte_in.
- States and transitions (each on an accepted byte unless noted):
  - SYNC0: byte==MAGIC[15:8] -> SYNC1; any other byte is discarded, stay.
  - SYNC1: byte==MAGIC[7:0] -> LEN_HI; byte==MAGIC[15:8] -> stay SYNC1; otherwise -> SYNC0.
  - LEN_HI: latch length[15:8] -> LEN_LO.
  - LEN_LO: latch length[7:0]. If length > 2**ADDR_W - BASE_ADDR -> ERROR. If length==0 -> CHECK. Otherwise -> DATA_HI. Clear checksum, index and words_loaded.
  - DATA_HI: latch hi byte, checksum += byte -> DATA_LO.
  - DATA_LO: checksum += byte. On the next cycle: wr_en=1, wr_data={hi,byte}, wr_addr=BASE_ADDR+index (wraps modulo 2**ADDR_W). Then index++ and words_loaded++. If index+1==length -> CHECK, else -> DATA_HI.
  - CHECK: byte==checksum (8-bit sum of all data bytes, mod 256) -> DONE, else -> ERROR.
  - DONE: done=1, cpu_reset=0, byte_ready=0. start -> SYNC0 with cpu_reset=1, done=0.
  - ERROR: error=1, cpu_reset=1, byte_ready=0. start -> SYNC0 with error=0.
- wr_en is high for exactly one cycle per word. wr_addr/wr_data are stable during that cycle and hold their values afterwards.
- Words are written as they arrive; a later checksum failure does not undo writes. cpu_reset stays high throughout.
- Timeout (TIMEOUT>0):
  - Counter runs in LEN_HI..CHECK and clears on every accepted byte.
  - When it reaches TIMEOUT with no accepted byte -> ERROR.
  - Not active in SYNC0/SYNC1.
- start is ignored in SYNC0..CHECK.
- rst_n low mid-frame aborts immediately to reset values; a partially written image is not cleared.

Test Plan:
- Reset/idle: hold rst_n low 3 cycles, then release -> all outputs at reset values; byte_ready=1 after first edge; cpu_reset=1.
- Nominal load, BASE_ADDR=0: bytes 48 4B 00 03 12 34 AB CD 00 01 BF (valid every cycle) -> wr_en pulses with (addr,data)=(0,1234),(1,ABCD),(2,0001); done=1, cpu_reset=0, words_loaded=3, byte_ready=0.
- Resync and bad checksum: bytes 00 48 48 4B 00 01 FF FF 00 -> one write (0,FFFF); error=1, cpu_reset=1. Then start pulse -> error=0, byte_ready=1, state SYNC0.
- Length bound, ADDR_W=4: bytes 48 4B 00 11 -> error=1, no wr_en. Bytes 48 4B 00 00 00 -> done=1, words_loaded=0.
- Timeout, TIMEOUT=16: bytes 48 4B 00 02 12, then byte_valid=0 for 16 cycles -> error=1, no wr_en. With TIMEOUT=0 the same stall holds in DATA_LO indefinitely.
- Async reset mid-frame: pull rst_n low between clk edges after the 6th data byte -> outputs immediately at reset values. A fresh nominal frame after release completes with done=1.
